// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Reads fetch a whole 16-byte line, writes touch a single 4-byte word.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                      input op_t op);
        logic [ADDR_W-1:0] mask;
        mask = (op == OP_RD) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFC;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_port_pick.sv
// Grant selection between icache refill and dcache write/refill; optional
// round-robin between the two groups when MEM_PORT_ARB_RR_EN is defined.
// Latency: combinational. Backpressure: none, evaluated only while the port is idle.
module mem_port_pick
    import mem_pkg::*;
(
    input  logic i_req,
    input  logic d_rd_req,
    input  logic d_wr_req,
`ifdef MEM_PORT_ARB_RR_EN
    input  logic rr_next,     // group to favour on a tie (OWN_I / OWN_D)
`endif
    output logic grant_vld,
    output logic owner,
    output logic op
);

    logic d_pend;
    logic pick_d;

    // Choose the group, then the dcache op (write before read inside the group).
    always_comb begin
        d_pend    = d_rd_req | d_wr_req;
        grant_vld = i_req | d_pend;
`ifdef MEM_PORT_ARB_RR_EN
        if (i_req && d_pend) begin
            pick_d = (rr_next == OWN_D);
        end else begin
            pick_d = d_pend;
        end
`else
        pick_d = d_pend;
`endif
        owner = pick_d ? OWN_D : OWN_I;
        op    = (pick_d && d_wr_req) ? OP_WR : OP_RD;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences icache/dcache transactions onto one RAM port; MEM_PORT_ARB_RR_EN selects round-robin.
// Latency: strobe MEM_LATENCY cycles after the sample cycle, done one cycle later (MEM_LATENCY+2 occupancy).
// Backpressure: requesters hold their request until done; nothing is sampled while busy.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_done,
    output logic [127:0]  i_rdata,
    input  logic          d_rd_req,
    input  logic          d_wr_req,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [127:0]  d_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [127:0]  mem_rdata,
    output logic          busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    owner_t     cur_own;
    op_t        cur_op;

    logic       pick_vld;
    logic       pick_own;
    logic       pick_op;

`ifdef MEM_PORT_ARB_RR_EN
    owner_t     rr_next;
`endif

    mem_port_pick u_pick (
        .i_req     (i_req),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
`ifdef MEM_PORT_ARB_RR_EN
        .rr_next   (rr_next),
`endif
        .grant_vld (pick_vld),
        .owner     (pick_own),
        .op        (pick_op)
    );

    // Transaction sequencer: grant in IDLE, hold the strobe for the access window, pulse done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_own   <= OWN_I;
            cur_op    <= OP_RD;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            rr_next   <= OWN_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cur_own  <= owner_t'(pick_own);
                        cur_op   <= op_t'(pick_op);
                        mem_addr <= align_addr((pick_own == OWN_D) ? d_addr : i_addr,
                                               op_t'(pick_op));
                        if (pick_op == OP_WR) begin
                            mem_wdata <= d_wdata;
                        end
                        mem_rd   <= (pick_op == OP_RD);
                        mem_wr   <= (pick_op == OP_WR);
                        cnt      <= CNT_LOAD;
                        busy     <= 1'b1;
                        state    <= ACCESS;
`ifdef MEM_PORT_ARB_RR_EN
                        rr_next  <= (pick_own == OWN_I) ? OWN_D : OWN_I;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // mem_rdata is only valid on this final access cycle.
                        if (cur_op == OP_RD) begin
                            if (cur_own == OWN_I) begin
                                i_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= mem_rdata;
                            end
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        i_done <= (cur_own == OWN_I);
                        d_done <= (cur_own == OWN_D);
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
